// File: rtl/lock_pkg.sv
// Shared types for the parametrised combination lock: state encoding and
// a helper that sizes counters from the number of values they must hold.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED   = 3'b000,
    ST_ENTRY    = 3'b001,
    ST_CHECK    = 3'b010,
    ST_UNLOCKED = 3'b011,
    ST_ERROR    = 3'b100,
    ST_LOCKOUT  = 3'b101,
    ST_PROG     = 3'b110
  } state_t;

  // Bits needed to encode n_values distinct values (never less than one bit).
  function automatic int unsigned bits_for(input int unsigned n_values);
    if (n_values <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n_values);
    end
  endfunction

endpackage

// File: rtl/combo_lock_param_btn_edge.sv
// Registered rising-edge detector for a bundle of level buttons; a held
// button yields exactly one press pulse.
module btn_edge #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] btn,
  output logic [W-1:0] press
);

  logic [W-1:0] btn_q;
  logic [W-1:0] btn_d;

  // Next value of the previous-level flops is simply the current level.
  always_comb begin
    btn_d = btn;
  end

  // Previous-level register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q <= '0;
    end else begin
      btn_q <= btn_d;
    end
  end

  assign press = btn & ~btn_q;

endmodule

// File: rtl/combo_lock_param.sv
// Parametrised digit-entry combination lock: on-the-fly code comparison,
// failure counting with timed lockout, idle timeout and in-place reprogramming.
module combo_lock_param
  import lock_pkg::*;
#(
  parameter int unsigned DIGIT_W        = 4,
  parameter int unsigned CODE_LEN       = 4,
  parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned ERROR_CYCLES   = 8,
  parameter int unsigned LOCKOUT_CYCLES = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DIGIT_W-1:0]             in_digit,
  input  logic                           enter_btn,
  input  logic                           lock_btn,
  input  logic                           prog_btn,
  output logic                           locked_led,
  output logic                           unlocked_led,
  output logic                           error_led,
  output logic                           lockout_led,
  output logic [2:0]                     state_leds,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

  localparam int unsigned CODE_W   = DIGIT_W * CODE_LEN;
  localparam int unsigned TRY_W    = $clog2(MAX_TRIES + 1);
  localparam int unsigned CNT_W    = bits_for(CODE_LEN + 1);
  localparam int unsigned HOLD_MAX = (ERROR_CYCLES > LOCKOUT_CYCLES) ? ERROR_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned HOLD_W   = bits_for(HOLD_MAX);
  localparam int unsigned IDLE_W   = bits_for(TIMEOUT_CYCLES);

  logic [2:0] press_s;
  logic       enter_press_s;
  logic       lock_press_s;
  logic       prog_press_s;

  btn_edge #(.W(3)) u_btn_edge (
    .clk   (clk),
    .reset (reset),
    .btn   ({prog_btn, lock_btn, enter_btn}),
    .press (press_s)
  );

  assign enter_press_s = press_s[0];
  assign lock_press_s  = press_s[1];
  assign prog_press_s  = press_s[2];

  state_t             state_q,     state_d;
  logic [CNT_W-1:0]   digit_cnt_q, digit_cnt_d;
  logic               mismatch_q,  mismatch_d;
  logic [TRY_W-1:0]   fail_q,      fail_d;
  logic [HOLD_W-1:0]  hold_q,      hold_d;
  logic [IDLE_W-1:0]  idle_q,      idle_d;
  logic [CODE_W-1:0]  code_q,      code_d;
  logic [CODE_W-1:0]  new_code_q,  new_code_d;

  logic [CODE_W-1:0]  code_shift_s;
  logic [DIGIT_W-1:0] cur_digit_s;
  logic [CODE_W-1:0]  shifted_code_s;
  logic               last_digit_s;
  logic               idle_expired_s;

  // Expected digit for the current position (first entered = MSB) and the
  // shadow code with the present digit shifted in.
  always_comb begin
    code_shift_s   = code_q >> (DIGIT_W * (CODE_LEN - 32'd1 - 32'(digit_cnt_q)));
    cur_digit_s    = code_shift_s[DIGIT_W-1:0];
    shifted_code_s = (new_code_q << DIGIT_W) | CODE_W'(in_digit);
    last_digit_s   = ((32'(digit_cnt_q) + 32'd1) == CODE_LEN);
    idle_expired_s = (32'(idle_q) == (TIMEOUT_CYCLES - 32'd1));
  end

  // Next-state, counter and code-register logic.
  always_comb begin
    state_d     = state_q;
    digit_cnt_d = digit_cnt_q;
    mismatch_d  = mismatch_q;
    fail_d      = fail_q;
    hold_d      = hold_q;
    idle_d      = idle_q;
    code_d      = code_q;
    new_code_d  = new_code_q;
    case (state_q)
      ST_LOCKED: begin
        if (enter_press_s) begin
          mismatch_d  = (in_digit != code_q[CODE_W-1 -: DIGIT_W]);
          digit_cnt_d = CNT_W'(1);
          idle_d      = '0;
          state_d     = (CODE_LEN == 32'd1) ? ST_CHECK : ST_ENTRY;
        end else begin
          digit_cnt_d = '0;
        end
      end
      ST_ENTRY: begin
        if (enter_press_s) begin
          mismatch_d  = mismatch_q | (in_digit != cur_digit_s);
          digit_cnt_d = digit_cnt_q + CNT_W'(1);
          idle_d      = '0;
          if (last_digit_s) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_ENTRY;
          end
        end else if (idle_expired_s) begin
          // Abandoned entry: back to LOCKED without touching fail_cnt.
          state_d     = ST_LOCKED;
          digit_cnt_d = '0;
          idle_d      = '0;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      ST_CHECK: begin
        digit_cnt_d = '0;
        mismatch_d  = 1'b0;
        if (!mismatch_q) begin
          fail_d  = '0;
          state_d = ST_UNLOCKED;
        end else if ((32'(fail_q) + 32'd1) < MAX_TRIES) begin
          fail_d  = fail_q + TRY_W'(1);
          hold_d  = HOLD_W'(ERROR_CYCLES - 32'd1);
          state_d = ST_ERROR;
        end else begin
          fail_d  = TRY_W'(MAX_TRIES);
          hold_d  = HOLD_W'(LOCKOUT_CYCLES - 32'd1);
          state_d = ST_LOCKOUT;
        end
      end
      ST_ERROR: begin
        if (hold_q == '0) begin
          state_d = ST_LOCKED;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      ST_LOCKOUT: begin
        if (hold_q == '0) begin
          fail_d  = '0;
          state_d = ST_LOCKED;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      ST_UNLOCKED: begin
        if (lock_press_s) begin
          state_d = ST_LOCKED;
        end else if (prog_press_s) begin
          digit_cnt_d = '0;
          idle_d      = '0;
          state_d     = ST_PROG;
        end else begin
          state_d = ST_UNLOCKED;
        end
      end
      ST_PROG: begin
        if (lock_press_s) begin
          // Abort wins over a simultaneous digit; stored code is untouched.
          digit_cnt_d = '0;
          idle_d      = '0;
          state_d     = ST_LOCKED;
        end else if (enter_press_s) begin
          new_code_d  = shifted_code_s;
          digit_cnt_d = digit_cnt_q + CNT_W'(1);
          idle_d      = '0;
          if (last_digit_s) begin
            code_d      = shifted_code_s;
            digit_cnt_d = '0;
            state_d     = ST_UNLOCKED;
          end else begin
            state_d = ST_PROG;
          end
        end else if (idle_expired_s) begin
          digit_cnt_d = '0;
          idle_d      = '0;
          state_d     = ST_LOCKED;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      default: begin
        digit_cnt_d = '0;
        mismatch_d  = 1'b0;
        state_d     = ST_LOCKED;
      end
    endcase
  end

  // State, counter, timer and code registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LOCKED;
      digit_cnt_q <= '0;
      mismatch_q  <= 1'b0;
      fail_q      <= '0;
      hold_q      <= '0;
      idle_q      <= '0;
      code_q      <= DEFAULT_CODE;
      new_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      digit_cnt_q <= digit_cnt_d;
      mismatch_q  <= mismatch_d;
      fail_q      <= fail_d;
      hold_q      <= hold_d;
      idle_q      <= idle_d;
      code_q      <= code_d;
      new_code_q  <= new_code_d;
    end
  end

  // Moore output decode of the state register and failure count.
  always_comb begin
    locked_led   = 1'b0;
    unlocked_led = 1'b0;
    error_led    = 1'b0;
    lockout_led  = 1'b0;
    case (state_q)
      ST_LOCKED, ST_ENTRY, ST_CHECK: begin
        locked_led = 1'b1;
      end
      ST_UNLOCKED, ST_PROG: begin
        unlocked_led = 1'b1;
      end
      ST_ERROR: begin
        locked_led = 1'b1;
        error_led  = 1'b1;
      end
      ST_LOCKOUT: begin
        locked_led  = 1'b1;
        error_led   = 1'b1;
        lockout_led = 1'b1;
      end
      default: begin
        locked_led = 1'b1;
      end
    endcase
    state_leds = state_q;
    tries_left = TRY_W'(MAX_TRIES) - fail_q;
  end

endmodule

// File: doc/combo_lock_param.md
Name: combo_lock_param

Overview:
Parametrised digit-entry combination lock core, the successor to the fixed lock core. It generalises digit width and code length and adds several features: a failed-attempt counter with timed lockout, an entry inactivity timeout, and re-programming of the code while unlocked. It sits under the top-level pin wrapper, and its LED outputs map directly to output pins.

Parameters:
DIGIT_W, 4, bits per entered digit
CODE_LEN, 4, digits per code (>=1)
DEFAULT_CODE, 16'h1234, reset code (DIGIT_W*CODE_LEN bits); first digit entered = most-significant digit
MAX_TRIES, 3, consecutive failures before lockout (>=1)
ERROR_CYCLES, 8, cycles the ERROR state is held
LOCKOUT_CYCLES, 1024, cycles the LOCKOUT state is held
TIMEOUT_CYCLES, 4096, idle cycles in ENTRY/PROG before abort

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
in_digit  in  DIGIT_W  digit value, sampled on an enter press
enter_btn  in  1  level; a press is its rising edge
lock_btn  in  1  level; rising edge relocks from UNLOCKED or aborts PROG
prog_btn  in  1  level; rising edge enters PROG from UNLOCKED
locked_led  out  1  high in LOCKED, ENTRY, CHECK, ERROR, LOCKOUT
unlocked_led  out  1  high in UNLOCKED, PROG
error_led  out  1  high in ERROR, LOCKOUT
lockout_led  out  1  high in LOCKOUT only
state_leds  out  3  state encoding
tries_left  out  clog2(MAX_TRIES+1)  MAX_TRIES minus the failure count

Behaviour:
- Inputs are synchronous to clk (synchronised upstream). Each button has a registered previous-value flop; press = btn & ~btn_q. Holding a button gives exactly one press.
- Outputs are a Moore decode of the state register plus fail_cnt. There is no extra output latency.
- State encoding: LOCKED=000, ENTRY=001, CHECK=010, UNLOCKED=011, ERROR=100, LOCKOUT=101, PROG=110.
- Reset, asynchronous and taking effect immediately mid-operation:
  - state=LOCKED, code=DEFAULT_CODE, fail_cnt=0, digit_cnt=0, all timers 0, mismatch=0, button flops 0.
  - Outputs after reset: locked_led=1, others 0, state_leds=000, tries_left=MAX_TRIES.
- Comparison is on the fly. No entered code is stored. mismatch |= (in_digit != code digit[digit_cnt]).
- LOCKED:
  - enter press: mismatch = (in_digit != digit 0), digit_cnt=1, idle timer cleared.
  - Next state is ENTRY, or CHECK directly if CODE_LEN==1.
  - lock/prog presses are ignored.
- ENTRY:
  - enter press: accumulate mismatch, digit_cnt++. When the incremented count equals CODE_LEN, go to CHECK.
  - The idle timer counts the cycles with no press. At TIMEOUT_CYCLES, return to LOCKED with digit_cnt=0. A timeout is not counted as a failure.
- CHECK lasts one cycle. Latency from the final digit press at cycle N: CHECK at N+1, result state at N+2.
  - Match: go to UNLOCKED, fail_cnt=0.
  - Mismatch with fail_cnt+1 < MAX_TRIES: fail_cnt++, go to ERROR, timer=ERROR_CYCLES-1.
  - Mismatch with fail_cnt+1 == MAX_TRIES: fail_cnt=MAX_TRIES, go to LOCKOUT, timer=LOCKOUT_CYCLES-1.
- ERROR: all presses ignored. The timer decrements each cycle; when it is 0, go to LOCKED. fail_cnt is kept.
- LOCKOUT: all presses ignored. When the timer is 0, go to LOCKED and clear fail_cnt.
- UNLOCKED:
  - lock press goes to LOCKED. prog press goes to PROG with digit_cnt=0.
  - If lock and prog are pressed in the same cycle, lock wins.
  - enter presses are ignored.
- PROG:
  - enter press shifts in_digit into a new_code shadow register and increments digit_cnt.
  - After CODE_LEN digits, code <= new_code in a single cycle (atomic update), then return to UNLOCKED.
  - lock press or idle timeout aborts: code is unchanged, go to LOCKED.
  - If lock and enter are pressed in the same cycle, lock wins and the digit is discarded.
- Timers are sized to clog2 of the largest count. No counter ever wraps; they saturate or reload only as listed above.

Decomposition:
- Package lock_pkg: state enum and encodings, and a clog2-based width helper.
- One sub-module, btn_edge: a parametrised-width registered rising-edge detector, instantiated once for enter/lock/prog.
- The FSM, timers and code registers stay in combo_lock_param.

Test Plan:
All scenarios use the defaults except ERROR_CYCLES=4, LOCKOUT_CYCLES=16 and TIMEOUT_CYCLES=32.
- Reset, then enter 1,2,3,4 (one press each) -> CHECK one cycle after the 4th press, then UNLOCKED: unlocked_led=1, state_leds=011, tries_left=3.
- Enter 1,2,3,5 -> ERROR for 4 cycles with error_led=1 and tries_left=2, then LOCKED. Enter_btn held high for 10 cycles -> counts as exactly one digit.
- Three wrong codes -> LOCKOUT: lockout_led=1, tries_left=0. Presses for 16 cycles are ignored, then LOCKED with tries_left=3. A correct code then unlocks.
- Unlock, prog press, enter 9,8,7,6 -> UNLOCKED. Lock press -> LOCKED. Code 1234 now fails; code 9876 unlocks.
- Enter 1,2 then idle 32 cycles -> LOCKED, tries_left still 3. In PROG, enter 5,5 then lock press -> LOCKED, code still 1234.
- Assert reset mid-ENTRY and mid-LOCKOUT -> immediate LOCKED, tries_left=3, and a reprogrammed code reverts to 1234.
